// File: rtl/load_store_queue.sv
// load_store_queue: in-order load/store buffer between issue and the memory unit.
// Entries wait for base/store-data operands by snooping the CDB. The oldest entry
// is presented to the memory unit once its operands are resolved.
// Optional build macro LSQ_STATS_EN adds issue/stall counters (stat_issued, stat_stall).
module load_store_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LW    = 4,
  parameter int unsigned DW    = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic                         disp_op,
  input  logic [LW-1:0]                disp_label,
  input  logic [LW-1:0]                disp_qj,
  input  logic [DW-1:0]                disp_vj,
  input  logic [DW-1:0]                disp_a,
  input  logic [LW-1:0]                disp_qk,
  input  logic [DW-1:0]                disp_vk,
  input  logic                         cdb_valid,
  input  logic [LW-1:0]                cdb_label,
  input  logic [DW-1:0]                cdb_data,
  output logic                         mem_wen,
  output logic                         mem_op,
  output logic [DW-1:0]                mem_base,
  output logic [DW-1:0]                mem_offset,
  output logic [DW-1:0]                mem_wdata,
  output logic [LW-1:0]                mem_label,
  input  logic                         mem_available,
`ifdef LSQ_STATS_EN
  output logic [15:0]                  stat_issued,
  output logic [15:0]                  stat_stall,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Entry storage
  logic          r_valid [DEPTH];
  logic          r_op    [DEPTH];
  logic [LW-1:0] r_label [DEPTH];
  logic [LW-1:0] r_qj    [DEPTH];
  logic [DW-1:0] r_vj    [DEPTH];
  logic [DW-1:0] r_a     [DEPTH];
  logic [LW-1:0] r_qk    [DEPTH];
  logic [DW-1:0] r_vk    [DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_disp_fire;
  logic          w_cdb_hit;
  logic          w_head_ready;
  logic          w_issue;
  logic [LW-1:0] w_new_qj;
  logic [DW-1:0] w_new_vj;
  logic [LW-1:0] w_new_qk;
  logic [DW-1:0] w_new_vk;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign disp_ready   = (r_count != CW'(DEPTH));
  assign w_disp_fire  = disp_valid && disp_ready;
  assign w_cdb_hit    = cdb_valid && (cdb_label != '0);
  assign w_head_ready = r_valid[r_head] && (r_qj[r_head] == '0) &&
                        (r_op[r_head] || (r_qk[r_head] == '0));
  assign mem_wen      = (r_count != '0) && w_head_ready;
  assign w_issue      = mem_wen && mem_available;
  assign count        = r_count;

  // Operand capture for the incoming entry, including same-cycle CDB bypass
  always_comb begin
    w_new_qj = disp_qj;
    w_new_vj = disp_vj;
    w_new_qk = disp_op ? '0 : disp_qk;
    w_new_vk = disp_vk;
    if (w_cdb_hit && (disp_qj == cdb_label)) begin
      w_new_qj = '0;
      w_new_vj = cdb_data;
    end
    if (w_cdb_hit && !disp_op && (disp_qk == cdb_label)) begin
      w_new_qk = '0;
      w_new_vk = cdb_data;
    end
  end

  // Head entry drives the memory request; data outputs are zero when idle
  always_comb begin
    mem_op     = 1'b0;
    mem_base   = '0;
    mem_offset = '0;
    mem_wdata  = '0;
    mem_label  = '0;
    if (mem_wen) begin
      mem_op     = r_op[r_head];
      mem_base   = r_vj[r_head];
      mem_offset = r_a[r_head];
      mem_wdata  = r_vk[r_head];
      mem_label  = r_label[r_head];
    end
  end

  // Entry array: CDB snoop, pop on issue, push on dispatch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_op[i]    <= 1'b0;
        r_label[i] <= '0;
        r_qj[i]    <= '0;
        r_vj[i]    <= '0;
        r_a[i]     <= '0;
        r_qk[i]    <= '0;
        r_vk[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_cdb_hit && r_valid[i]) begin
          if (r_qj[i] == cdb_label) begin
            r_qj[i] <= '0;
            r_vj[i] <= cdb_data;
          end
          if (r_qk[i] == cdb_label) begin
            r_qk[i] <= '0;
            r_vk[i] <= cdb_data;
          end
        end
      end
      // Head and tail only coincide when empty (no issue) or full (no dispatch).
      if (w_issue) begin
        r_valid[r_head] <= 1'b0;
      end
      if (w_disp_fire) begin
        r_valid[r_tail] <= 1'b1;
        r_op[r_tail]    <= disp_op;
        r_label[r_tail] <= disp_label;
        r_qj[r_tail]    <= w_new_qj;
        r_vj[r_tail]    <= w_new_vj;
        r_a[r_tail]     <= disp_a;
        r_qk[r_tail]    <= w_new_qk;
        r_vk[r_tail]    <= w_new_vk;
      end
    end
  end

  // Head/tail pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_issue) begin
        r_head <= ptr_inc(r_head);
      end
      if (w_disp_fire) begin
        r_tail <= ptr_inc(r_tail);
      end
      case ({w_disp_fire, w_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef LSQ_STATS_EN
  logic [15:0] r_stat_issued;
  logic [15:0] r_stat_stall;

  // Free-running wrap-around counters of issues and memory back-pressure cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_issued <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_issue) begin
        r_stat_issued <= r_stat_issued + 16'd1;
      end
      if (mem_wen && !mem_available) begin
        r_stat_stall <= r_stat_stall + 16'd1;
      end
    end
  end

  assign stat_issued = r_stat_issued;
  assign stat_stall  = r_stat_stall;
`endif

endmodule

// File: doc/load_store_queue.md
# load_store_queue

In-order load/store buffer feeding the memory unit in the Tomasulo datapath. It accepts load/store instructions from the issue stage and holds them while their base and store-data operands are still pending. It snoops the CDB to capture operands. It drives the memory unit's request port (`WEN`, address halves, `op`, write data, label) one instruction at a time, oldest first.

## Interface
Parameters:
- `DEPTH`, 4, number of entries (≥2, any integer).
- `LW`, 4, label (tag) width. Label 0 means "no producer / value valid".
- `DW`, 32, data and address width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `disp_valid`  in  1  dispatch request.
- `disp_ready`  out  1  entry available (`!full`).
- `disp_op`  in  1  1 = load, 0 = store.
- `disp_label`  in  LW  instruction label, returned on `mem_label`.
- `disp_qj`  in  LW  producer tag of base; 0 = `disp_vj` valid.
- `disp_vj`  in  DW  base value.
- `disp_a`  in  DW  immediate offset.
- `disp_qk`  in  LW  producer tag of store data; 0 = `disp_vk` valid (ignored for loads).
- `disp_vk`  in  DW  store data.
- `cdb_valid`  in  1  CDB broadcast valid.
- `cdb_label`  in  LW  CDB tag.
- `cdb_data`  in  DW  CDB value.
- `mem_wen`  out  1  request to memory unit.
- `mem_op`  out  1  1 = load, 0 = store.
- `mem_base`  out  DW  base (memory `dataIn1`).
- `mem_offset`  out  DW  offset (memory `dataIn2`).
- `mem_wdata`  out  DW  store data.
- `mem_label`  out  LW  label.
- `mem_available`  in  1  memory accepts request this edge.
- `count`  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Circular buffer with `head`/`tail` pointers, each wrapping `DEPTH-1`→0, plus `count`. Full when `count==DEPTH`; empty when `count==0`.
- Entry fields: valid, op, label, qj, vj, a, qk, vk.
- Dispatch fires on `disp_valid && disp_ready`. It writes the entry at `tail` and increments `tail`. For loads, qk is forced to 0.
- CDB snoop: each edge with `cdb_valid && cdb_label!=0`, every valid entry whose qj (qk) equals `cdb_label` loads `cdb_data` into vj (vk) and clears the tag.
- Dispatch bypass: a dispatch whose `disp_qj`/`disp_qk` matches a same-cycle valid CDB tag stores `cdb_data` and a cleared tag.
- Head ready = valid && qj==0 && (op==1 || qk==0).
- `mem_wen` = !empty && head ready. It is combinational from registered entry state.
- While `mem_wen=1`, `mem_*` show the head entry. While `mem_wen=0`, all `mem_*` data outputs are 0.
- Issue fires on `mem_wen && mem_available`. The head is popped at that edge.
- Strict in-order: a younger ready entry never issues past a blocked head.
- Simultaneous dispatch and issue: `count` is unchanged and both pointers advance.

## Timing
- Reset (async, any time, including mid-handshake): all entries invalid, `head=tail=count=0`, `disp_ready=1`, `mem_wen=0`, all `mem_*` outputs 0.
- Dispatch of a fully ready instruction into an empty queue: `mem_wen=1` in the next cycle (1-cycle latency).
- CDB wake-up of the head at edge N: `mem_wen=1` during cycle N+1. There is no combinational CDB→`mem_*` path.
- `mem_*` hold stable while `mem_wen=1 && mem_available=0`.
- Back-to-back issues are allowed on consecutive edges if the memory keeps `mem_available=1`.
- `disp_ready` depends on registered `count` only. A full queue rejects dispatch even in a cycle where the head issues.

## Configuration
- `LSQ_STATS_EN` defined: adds two outputs, `stat_issued` (16-bit) and `stat_stall` (16-bit).
  - `stat_issued` counts issue fires.
  - `stat_stall` counts cycles with `mem_wen && !mem_available`.
  - Both wrap at 0xFFFF→0 and reset to 0.
- Undefined: neither port nor counter exists.

## Test plan
- Ready load (qj=0, vj=0x100, a=0x8, label=3), `mem_available=1` → next cycle `mem_wen=1`, `mem_base=0x100`, `mem_offset=0x8`, `mem_label=3`, `mem_op=1`; following cycle `count=0`, `mem_wen=0`.
- Store with qk=5, vk=X → `mem_wen=0` until CDB (label 5, 0xDEAD) → next cycle `mem_wen=1`, `mem_wdata=0xDEAD`, `mem_op=0`.
- Dispatch qj=7 in the same cycle as CDB label 7, data 0x40 → entry issues with `mem_base=0x40`.
- Head blocked (qj=2), second entry ready → `mem_wen=0` until CDB label 2; then head issues, then second entry on the next edge.
- Four ready dispatches with `mem_available=0` → `count=4`, `disp_ready=0`, `mem_*` stable; raise `mem_available` → pops in order, pointers wrap.
- Assert `rst_n=0` while `mem_wen=1` with 3 entries → immediately `mem_wen=0`, `count=0`, `disp_ready=1`; with `LSQ_STATS_EN`, both counters read 0.
